// File: rtl/z80_bus_bridge.sv
// Bridges Z80 CPU bus cycles (memory, I/O, interrupt acknowledge) to a simple
// req/ack back-end, stretching the CPU with nWAIT until the back-end answers.
module z80_bus_bridge #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MIN_WAIT = 1,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              nMREQ,
    input  logic              nIORQ,
    input  logic              nRD,
    input  logic              nWR,
    input  logic              nM1,
    input  logic              nRFSH,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D_in,
    output logic              nWAIT,
    output logic [DATA_W-1:0] D_out,
    output logic              D_oe,
    output logic              req,
    output logic              we,
    output logic              io,
    output logic              inta,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              ack,
    input  logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT1_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT1_W-1:0]  cnt_inc;
    logic               got_ack, got_ack_nxt;
    logic               min_met;
    logic               mem_start, io_start, inta_start, strobes_off;
    logic               nwait_nxt, doe_nxt, req_nxt, we_nxt, io_nxt, inta_nxt, err_nxt;
    logic [DATA_W-1:0]  data_nxt, wdata_nxt;
    logic [ADDR_W-1:0]  addr_nxt;

    // Cycle-type decode; refresh (nRFSH low) never qualifies as a memory cycle
    assign mem_start   = !nMREQ && nRFSH && (!nRD || !nWR);
    assign io_start    = !nIORQ && nM1 && (!nRD || !nWR);
    assign inta_start  = !nIORQ && !nM1;
    assign strobes_off = nMREQ && nIORQ;

    // One extra bit keeps the minimum-wait test meaningful when MIN_WAIT is 0
    assign cnt_inc = {1'b0, cnt} + CNT1_W'(1);
    assign min_met = 32'(cnt_inc) > MIN_WAIT;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        got_ack_nxt = got_ack;
        data_nxt    = D_out;
        err_nxt     = err;
        req_nxt     = 1'b0;
        we_nxt      = we;
        io_nxt      = io;
        inta_nxt    = inta;
        addr_nxt    = addr;
        wdata_nxt   = wdata;

        case (state)
            IDLE: begin
                if (mem_start || io_start || inta_start) begin
                    state_nxt   = WAIT;
                    req_nxt     = 1'b1;
                    cnt_nxt     = '0;
                    got_ack_nxt = 1'b0;
                    addr_nxt    = A;
                    wdata_nxt   = D_in;
                    we_nxt      = !nWR;
                    io_nxt      = !nIORQ;
                    inta_nxt    = inta_start;
                end
            end
            WAIT: begin
                if (strobes_off) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt_inc[CNT_W-1:0];
                    if (ack && !got_ack) begin
                        data_nxt    = rdata;
                        got_ack_nxt = 1'b1;
                    end
                    // An ack arriving on the timeout cycle still counts as success
                    if ((got_ack || ack) && min_met) begin
                        state_nxt = HOLD;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = HOLD;
                        data_nxt  = '1;
                        err_nxt   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (strobes_off) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        nwait_nxt = (state_nxt != WAIT);
        doe_nxt   = (state_nxt == HOLD) && (!we_nxt || inta_nxt);
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            got_ack <= 1'b0;
            nWAIT   <= 1'b1;
            D_oe    <= 1'b0;
            D_out   <= '0;
            req     <= 1'b0;
            we      <= 1'b0;
            io      <= 1'b0;
            inta    <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            got_ack <= got_ack_nxt;
            nWAIT   <= nwait_nxt;
            D_oe    <= doe_nxt;
            D_out   <= data_nxt;
            req     <= req_nxt;
            we      <= we_nxt;
            io      <= io_nxt;
            inta    <= inta_nxt;
            addr    <= addr_nxt;
            wdata   <= wdata_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Bench for z80_bus_bridge: three instances with different wait/timeout settings
// share one CPU bus; directed vectors plus randomized traffic against a model.
module tb_z80_bus_bridge;

    localparam int NI = 3;
    localparam int unsigned MW [NI] = '{1, 2, 0};
    localparam int unsigned TO [NI] = '{15, 15, 4};

    // Strobe bundles ordered {nMREQ, nIORQ, nRD, nWR, nM1, nRFSH}
    localparam logic [5:0] S_IDLE = 6'b111111;
    localparam logic [5:0] S_MRD  = 6'b010111;
    localparam logic [5:0] S_MWR  = 6'b011011;
    localparam logic [5:0] S_IORD = 6'b100111;
    localparam logic [5:0] S_IOWR = 6'b101011;
    localparam logic [5:0] S_INTA = 6'b101101;
    localparam logic [5:0] S_RFSH = 6'b011110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh;
    logic [15:0] a_in;
    logic [7:0]  d_in;
    logic        ack;
    logic [7:0]  rdata;

    logic [NI-1:0] nwait_v, doe_v, req_v, we_v, io_v, inta_v, err_v;
    logic [7:0]    dout_v  [NI];
    logic [7:0]    wdata_v [NI];
    logic [15:0]   addr_v  [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        z80_bus_bridge #(
            .ADDR_W(16), .DATA_W(8), .MIN_WAIT(MW[g]), .TIMEOUT(TO[g])
        ) u_dut (
            .CLK(clk), .nRESET(rst_n),
            .nMREQ(n_mreq), .nIORQ(n_iorq), .nRD(n_rd), .nWR(n_wr),
            .nM1(n_m1), .nRFSH(n_rfsh), .A(a_in), .D_in(d_in),
            .nWAIT(nwait_v[g]), .D_out(dout_v[g]), .D_oe(doe_v[g]),
            .req(req_v[g]), .we(we_v[g]), .io(io_v[g]), .inta(inta_v[g]),
            .addr(addr_v[g]), .wdata(wdata_v[g]),
            .ack(ack), .rdata(rdata), .err(err_v[g])
        );
    end

    // Transaction-level reference: ph 0 idle, 1 stretching (k = wait cycle number), 2 driving
    typedef struct {
        int          ph;
        int          k;
        logic        acked;
        logic        wr;
        logic        iox;
        logic        ia;
        logic        er;
        logic [15:0] ad;
        logic [7:0]  wd;
        logic [7:0]  dat;
    } mdl_t;

    mdl_t m [NI];

    function automatic mdl_t mreset();
        mdl_t r;
        r.ph = 0; r.k = 0; r.acked = 1'b0; r.wr = 1'b0; r.iox = 1'b0;
        r.ia = 1'b0; r.er = 1'b0; r.ad = '0; r.wd = '0; r.dat = '0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t s, int mn, int tmo, logic [5:0] st,
                                   logic [15:0] a, logic [7:0] d, logic ak, logic [7:0] rv);
        mdl_t r = s;
        logic mreq, iorq, rdn, wrn, m1, rfsh;
        logic is_mem, is_io, is_ia, off;
        int   waited;
        {mreq, iorq, rdn, wrn, m1, rfsh} = st;
        is_mem = !mreq && rfsh && (!rdn || !wrn);
        is_io  = !iorq && m1 && (!rdn || !wrn);
        is_ia  = !iorq && !m1;
        off    = mreq && iorq;
        if (r.ph == 0) begin
            if (is_mem || is_io || is_ia) begin
                r.ph = 1; r.k = 1; r.acked = 1'b0;
                r.ad = a; r.wd = d; r.wr = !wrn; r.iox = !iorq; r.ia = is_ia;
            end
        end else if (r.ph == 1) begin
            if (off) begin
                r.ph = 0;
            end else begin
                waited = r.k - 1;
                if (ak && !r.acked) begin
                    r.dat = rv;
                    r.acked = 1'b1;
                end
                if (r.acked && waited >= mn) r.ph = 2;
                else if (waited >= tmo) begin
                    r.dat = 8'hFF; r.er = 1'b1; r.ph = 2;
                end else r.k = r.k + 1;
            end
        end else if (off) begin
            r.ph = 0;
        end
        return r;
    endfunction

    function automatic logic [38:0] mexp(mdl_t s);
        return {(s.ph == 1 && s.k == 1), (s.ph != 1), (s.ph == 2 && (!s.wr || s.ia)),
                s.dat, s.wr, s.iox, s.ia, s.ad, s.wd, s.er};
    endfunction

    function automatic logic [38:0] obs(int g);
        return {req_v[g], nwait_v[g], doe_v[g], dout_v[g], we_v[g], io_v[g], inta_v[g],
                addr_v[g], wdata_v[g], err_v[g]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_s(input logic [5:0] s);
        {n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh} = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_s(S_IDLE);
        ack = 1'b0; rdata = '0; a_in = '0; d_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one bus cycle for 30 clocks then releases the strobes; ack_at is the wait cycle number
    task automatic txn(input logic [5:0] s, input logic [15:0] av, input logic [7:0] dv,
                       input int ack_at, input logic [7:0] rv,
                       output int wa, output int wb, output int wc, output int reqs,
                       output logic [NI-1:0] oe, output logic [7:0] dq);
        wa = 0; wb = 0; wc = 0; reqs = 0; oe = '0; dq = '0;
        set_s(s); a_in = av; d_in = dv; rdata = rv; ack = 1'b0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (!nwait_v[0]) wa++;
            if (!nwait_v[1]) wb++;
            if (!nwait_v[2]) wc++;
            if (req_v[0]) reqs++;
            oe = oe | doe_v;
            if (i == 29) begin
                dq = dout_v[0];
                set_s(S_IDLE);
            end
            ack = (i == ack_at - 1);
        end
        ack = 1'b0;
    endtask

    typedef struct {
        logic [5:0]  s;
        logic [15:0] a;
        logic        ak;
        logic [7:0]  rd;
        logic        req;
        logic        nwait;
        logic        doe;
        logic [7:0]  dout;
        logic        we;
        logic [15:0] ad;
    } vec_t;

    localparam logic [5:0] KINDS [8] = '{S_MRD, S_MWR, S_IORD, S_IOWR, S_INTA, S_RFSH, S_IDLE, S_IDLE};

    initial begin
        vec_t        tbl [7];
        logic [38:0] rst_obs;
        int          wa, wb, wc, reqs, rem;
        logic [NI-1:0] oe;
        logic [7:0]  dq;
        logic [5:0]  cur_s;

        rst_obs = {1'b0, 1'b1, 37'd0};

        // Memory read, ack on the third stretched cycle
        tbl[0] = '{S_MRD,  16'h1234, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h1234};
        tbl[1] = '{S_MRD,  16'h1234, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h1234};
        tbl[2] = '{S_MRD,  16'h1234, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h1234};
        tbl[3] = '{S_MRD,  16'h1234, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 16'h1234};
        tbl[4] = '{S_MRD,  16'h1234, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 16'h1234};
        tbl[5] = '{S_IDLE, 16'h1234, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 16'h1234};
        tbl[6] = '{S_IDLE, 16'h1234, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 16'h1234};

        rst_n = 1'b0;
        set_s(S_IDLE);
        ack = 1'b0; rdata = '0; a_in = '0; d_in = '0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) chk($sformatf("reset_state%0d", g), 64'(obs(g)), 64'(rst_obs));
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            set_s(tbl[i].s); a_in = tbl[i].a; ack = tbl[i].ak; rdata = tbl[i].rd;
            @(negedge clk);
            chk($sformatf("mem_rd_vec%0d", i),
                64'({req_v[0], nwait_v[0], doe_v[0], dout_v[0], we_v[0], addr_v[0]}),
                64'({tbl[i].req, tbl[i].nwait, tbl[i].doe, tbl[i].dout, tbl[i].we, tbl[i].ad}));
        end
        ack = 1'b0;

        do_reset();
        txn(S_IOWR, 16'h00FE, 8'h77, 1, 8'h00, wa, wb, wc, reqs, oe, dq);
        chk("io_wr_wait_min2", 64'(wb), 64'(3));
        chk("io_wr_wait_min1", 64'(wa), 64'(2));
        chk("io_wr_wait_min0", 64'(wc), 64'(1));
        chk("io_wr_req_pulses", 64'(reqs), 64'(1));
        chk("io_wr_no_doe", 64'(oe), 64'(0));
        chk("io_wr_latch", 64'({io_v[1], we_v[1], wdata_v[1], addr_v[1]}), 64'({1'b1, 1'b1, 8'h77, 16'h00FE}));

        do_reset();
        txn(S_MRD, 16'h4000, 8'h00, 0, 8'h00, wa, wb, wc, reqs, oe, dq);
        chk("timeout_wait_to15", 64'(wa), 64'(16));
        chk("timeout_wait_to4", 64'(wc), 64'(5));
        chk("timeout_data", 64'(dq), 64'(8'hFF));
        chk("timeout_doe", 64'(oe[0]), 64'(1));
        chk("timeout_err", 64'(err_v), 64'(3'b111));

        txn(S_MRD, 16'h4001, 8'h00, 2, 8'h3C, wa, wb, wc, reqs, oe, dq);
        chk("after_to_data", 64'(dq), 64'(8'h3C));
        chk("after_to_wait", 64'(wa), 64'(2));
        chk("err_sticky", 64'(err_v[0]), 64'(1));

        txn(S_RFSH, 16'h0055, 8'h00, 1, 8'h99, wa, wb, wc, reqs, oe, dq);
        chk("refresh_no_wait", 64'(wa), 64'(0));
        chk("refresh_no_req", 64'(reqs), 64'(0));

        txn(S_INTA, 16'h0038, 8'h00, 1, 8'hFF, wa, wb, wc, reqs, oe, dq);
        chk("inta_flags", 64'({inta_v[0], io_v[0], we_v[0]}), 64'(3'b110));
        chk("inta_doe", 64'(oe[0]), 64'(1));
        chk("inta_data", 64'(dq), 64'(8'hFF));
        chk("inta_wait", 64'(wa), 64'(2));

        do_reset();
        set_s(S_MRD); a_in = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 64'(obs(0)), 64'(rst_obs));
        set_s(S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        ack = 1'b1; rdata = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_reset_ack%0d", i), 64'(obs(0)), 64'(rst_obs));
        end
        ack = 1'b0;

        do_reset();
        txn(S_MRD, 16'h2222, 8'h00, 5, 8'h81, wa, wb, wc, reqs, oe, dq);
        chk("ack_at_timeout_err", 64'(err_v), 64'(0));
        chk("ack_at_timeout_data", 64'(dout_v[2]), 64'(8'h81));
        chk("ack_at_timeout_wait", 64'(wc), 64'(5));
        chk("ack_late_wait_min1", 64'(wa), 64'(5));

        do_reset();
        for (int g = 0; g < NI; g++) m[g] = mreset();
        rem = 0;
        cur_s = S_IDLE;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (rem == 0) begin
                cur_s = KINDS[$urandom_range(0, 7)];
                rem   = $urandom_range(1, 24);
                a_in  = 16'($urandom);
                d_in  = 8'($urandom);
            end
            rem--;
            set_s(cur_s);
            ack   = ($urandom_range(0, 3) == 0);
            rdata = 8'($urandom);
            for (int g = 0; g < NI; g++)
                m[g] = mstep(m[g], int'(MW[g]), int'(TO[g]), cur_s, a_in, d_in, ack, rdata);
            @(negedge clk);
            for (int g = 0; g < NI; g++)
                chk($sformatf("rand_c%0d_u%0d", cyc, g), 64'(obs(g)), 64'(mexp(m[g])));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
